// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRST_HALF,
    SECOND_HALF,
    GAP,
    HOLD,
    DONE
  } spi_state_t;

  // SPI modes as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_param_timer.sv
// Loadable down-counter shared by every timed state of the SPI master.
module spi_delay_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] len,
  output logic        expired
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= len;
    else if (count != '0)
      count <= count - 32'd1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with runtime CPOL/CPHA, grouped bit gaps and
// one-hot slave selects; all SPI timing is counted in clk cycles.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int GROUP_W   = 8,
  parameter int NUM_SS    = 1,
  parameter int CLK_DIV   = 25,
  parameter int SETUP_CYC = 100,
  parameter int GAP_CYC   = 50,
  parameter int HOLD_CYC  = 50
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic [clog2_min1(NUM_SS)-1:0] ss_sel,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          sclk,
  output logic                          mosi,
  input  logic                          miso,
  output logic [NUM_SS-1:0]             ss_n
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  spi_state_t        state, next_state;
  logic              cpol_q, cpha_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [CNT_W-1:0]  bit_cnt;
  logic              load, expired;
  logic [31:0]       len;
  logic              start_ok, all_bits, cur_last, group_end;
  logic              enter_lead, enter_trail, sample_on_lead;

  // bit_cnt counts completed bits; it steps on every trailing edge
  assign start_ok    = start && (32'(ss_sel) < NUM_SS);
  assign all_bits    = (bit_cnt == CNT_W'(DATA_W));
  assign cur_last    = (bit_cnt == CNT_W'(DATA_W - 1));
  assign group_end   = ((32'(bit_cnt) % GROUP_W) == 0);
  assign enter_lead  = (next_state == FIRST_HALF) && (state != FIRST_HALF);
  assign enter_trail = (state == FIRST_HALF) && (next_state == SECOND_HALF);

  always_comb begin
    case ({cpol_q, cpha_q})
      MODE0, MODE2: sample_on_lead = 1'b1;
      MODE1, MODE3: sample_on_lead = 1'b0;
      default:      sample_on_lead = 1'b1;
    endcase
  end

  spi_delay_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .len     (len),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (start_ok) next_state = SETUP;
      SETUP:       if (expired) next_state = FIRST_HALF;
      FIRST_HALF:  if (expired) next_state = SECOND_HALF;
      SECOND_HALF: if (expired) begin
        if (all_bits)       next_state = HOLD;
        else if (group_end) next_state = GAP;
        else                next_state = FIRST_HALF;
      end
      GAP:         if (expired) next_state = FIRST_HALF;
      HOLD:        if (expired) next_state = DONE;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Timer is reloaded on every state change with the new state's length
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    load = (next_state != state);
    case (next_state)
      SETUP:                   len = 32'(SETUP_CYC - 1);
      FIRST_HALF, SECOND_HALF: len = 32'(CLK_DIV - 1);
      GAP:                     len = 32'(GAP_CYC - 1);
      HOLD:                    len = 32'(HOLD_CYC - 1);
      default:                 len = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss_n    <= '1;
      rx_data <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE && start_ok) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        sclk    <= cpol;
        bit_cnt <= '0;
        ss_n    <= ~(NUM_SS'(1) << ss_sel);
        if (cpha) begin
          tx_sh <= tx_data;
        end else begin
          mosi  <= tx_data[DATA_W-1];
          tx_sh <= tx_data << 1;
        end
      end
      if (enter_lead) begin
        sclk <= ~cpol_q;
        if (sample_on_lead) begin
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
        end else begin
          mosi  <= tx_sh[DATA_W-1];
          tx_sh <= tx_sh << 1;
        end
      end
      if (enter_trail) begin
        sclk    <= cpol_q;
        bit_cnt <= bit_cnt + 1'b1;
        if (!sample_on_lead) begin
          rx_sh <= {rx_sh[DATA_W-2:0], miso};
        end else if (!cur_last) begin
          mosi  <= tx_sh[DATA_W-1];
          tx_sh <= tx_sh << 1;
        end
      end
      if (state == HOLD && next_state == DONE) begin
        ss_n    <= '1;
        mosi    <= 1'b0;
        rx_data <= rx_sh;
      end
    end
  end

endmodule
